// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - TD4 opcodes, ALU select codes and FSM states shared by fetch/decode
// TD4_ILLEGAL_TRAP_EN adds the ST_HALT state used by the illegal-opcode trap.
package td4_pkg;

    localparam int IM_W_DEF = 4;

    localparam logic [3:0] OP_ADD_A = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A = 4'b0010;
    localparam logic [3:0] OP_MOV_A = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B = 4'b0101;
    localparam logic [3:0] OP_IN_B = 4'b0110;
    localparam logic [3:0] OP_MOV_B = 4'b0111;
    localparam logic [3:0] OP_OUT_B = 4'b1001;
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_JNC = 4'b1110;
    localparam logic [3:0] OP_JMP = 4'b1111;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_IN = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

`ifdef TD4_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/td4_decode.sv
// rtl/td4_decode.sv - combinational TD4 opcode decode to active-low loads and ALU select
// With TD4_ILLEGAL_TRAP_EN undefined opcodes raise o_illegal; otherwise they are plain NOPs.
module td4_decode
    import td4_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic       i_cf,
    output logic       o_load_a,
    output logic       o_load_b,
    output logic       o_load_out,
    output logic       o_load_pc,
    output logic [1:0] o_sel,
    output logic       o_illegal
);

    always_comb begin
        o_load_a   = 1'b1;
        o_load_b   = 1'b1;
        o_load_out = 1'b1;
        o_load_pc  = 1'b1;
        o_sel      = SEL_ZERO;
        o_illegal  = 1'b0;
        case (i_op)
            OP_ADD_A:  begin o_sel = SEL_A;    o_load_a   = 1'b0; end
            OP_ADD_B:  begin o_sel = SEL_B;    o_load_b   = 1'b0; end
            OP_MOV_A:  begin o_sel = SEL_ZERO; o_load_a   = 1'b0; end
            OP_MOV_B:  begin o_sel = SEL_ZERO; o_load_b   = 1'b0; end
            OP_MOV_AB: begin o_sel = SEL_B;    o_load_a   = 1'b0; end
            OP_MOV_BA: begin o_sel = SEL_A;    o_load_b   = 1'b0; end
            OP_IN_A:   begin o_sel = SEL_IN;   o_load_a   = 1'b0; end
            OP_IN_B:   begin o_sel = SEL_IN;   o_load_b   = 1'b0; end
            OP_OUT_IM: begin o_sel = SEL_ZERO; o_load_out = 1'b0; end
            OP_OUT_B:  begin o_sel = SEL_B;    o_load_out = 1'b0; end
            OP_JMP:    begin o_sel = SEL_ZERO; o_load_pc  = 1'b0; end
            // jump taken only when no carry; carry set leaves the PC to increment
            OP_JNC:    begin o_sel = SEL_ZERO; o_load_pc  = i_cf; end
            default: begin
`ifdef TD4_ILLEGAL_TRAP_EN
                o_illegal = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/td4_fetch_decode.sv
// rtl/td4_fetch_decode.sv - TD4 fetch/decode: ROM req/ack fetch with timeout, IR, one-cycle execute strobe
// TD4_ILLEGAL_TRAP_EN enables the sticky illegal flag and HALT on undefined opcodes.
module td4_fetch_decode
    import td4_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int IM_W    = IM_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic            i_run,
    input  logic [IM_W-1:0] i_pc,
    input  logic            i_cf,
    output logic            o_rom_req,
    output logic [IM_W-1:0] o_rom_addr,
    input  logic            i_rom_ack,
    input  logic [7:0]      i_rom_data,
    output logic            o_exec,
    output logic            o_load_a,
    output logic            o_load_b,
    output logic            o_load_out,
    output logic            o_load_pc,
    output logic [IM_W-1:0] o_im,
    output logic [1:0]      o_sel,
    output logic            o_fault,
    output logic            o_illegal
);

    state_t          r_state;
    logic [7:0]      r_ir;
    logic [7:0]      r_cnt;
    logic            r_req;
    logic [IM_W-1:0] r_addr;
    logic            r_exec;
    logic            r_tmo;
    logic            r_fault;
    logic            r_illegal;

    logic            w_load_a;
    logic            w_load_b;
    logic            w_load_out;
    logic            w_load_pc;
    logic [1:0]      w_sel;
    logic            w_illegal;
    logic            w_live;

    td4_decode u_decode (
        .i_op       (r_ir[7:4]),
        .i_cf       (i_cf),
        .o_load_a   (w_load_a),
        .o_load_b   (w_load_b),
        .o_load_out (w_load_out),
        .o_load_pc  (w_load_pc),
        .o_sel      (w_sel),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state   <= ST_IDLE;
            r_ir      <= 8'h00;
            r_cnt     <= 8'd0;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_exec    <= 1'b0;
            r_tmo     <= 1'b0;
            r_fault   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= r_illegal | (r_exec & w_illegal);
            case (r_state)
                ST_IDLE: begin
                    if (i_run) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                        r_addr  <= i_pc;
                        r_cnt   <= 8'd0;
                    end
                end
                ST_FETCH: begin
                    if (i_rom_ack && r_req) begin
                        r_ir    <= i_rom_data;
                        r_req   <= 1'b0;
                        r_exec  <= 1'b1;
                        r_tmo   <= 1'b0;
                        r_state <= ST_EXEC;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        // IR 00 would decode as ADD A; r_tmo masks every load for this pass
                        r_ir    <= 8'h00;
                        r_req   <= 1'b0;
                        r_exec  <= 1'b1;
                        r_tmo   <= 1'b1;
                        r_fault <= 1'b1;
                        r_state <= ST_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_EXEC: begin
                    r_exec <= 1'b0;
                    r_tmo  <= 1'b0;
`ifdef TD4_ILLEGAL_TRAP_EN
                    if (w_illegal) begin
                        r_state <= ST_HALT;
                    end else if (i_run) begin
`else
                    if (i_run) begin
`endif
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                        r_addr  <= i_pc;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef TD4_ILLEGAL_TRAP_EN
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_exec  <= 1'b0;
                end
            endcase
        end
    end

    assign w_live     = r_exec & ~r_tmo;
    assign o_rom_req  = r_req;
    assign o_rom_addr = r_addr;
    assign o_exec     = r_exec;
    assign o_load_a   = w_live ? w_load_a   : 1'b1;
    assign o_load_b   = w_live ? w_load_b   : 1'b1;
    assign o_load_out = w_live ? w_load_out : 1'b1;
    assign o_load_pc  = w_live ? w_load_pc  : 1'b1;
    assign o_sel      = w_live ? w_sel      : SEL_ZERO;
    assign o_im       = IM_W'(r_ir[3:0]);
    assign o_fault    = r_fault;
    assign o_illegal  = r_illegal;

endmodule

// File: tb/tb_td4_fetch_decode.sv
// tb/tb_td4_fetch_decode.sv - table-driven scoreboard bench for td4_fetch_decode
module tb_td4_fetch_decode;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       clr, run, cf, rom_ack;
    logic [3:0] pc;
    logic [7:0] rom_data;
    logic       rom_req, exec, load_a, load_b, load_out, load_pc, fault, illegal;
    logic [3:0] rom_addr, im;
    logic [1:0] sel;

    td4_fetch_decode #(.TIMEOUT(TMO), .IM_W(4)) dut (
        .i_clk      (clk),
        .i_clr      (clr),
        .i_run      (run),
        .i_pc       (pc),
        .i_cf       (cf),
        .o_rom_req  (rom_req),
        .o_rom_addr (rom_addr),
        .i_rom_ack  (rom_ack),
        .i_rom_data (rom_data),
        .o_exec     (exec),
        .o_load_a   (load_a),
        .o_load_b   (load_b),
        .o_load_out (load_out),
        .o_load_pc  (load_pc),
        .o_im       (im),
        .o_sel      (sel),
        .o_fault    (fault),
        .o_illegal  (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] loads;
        logic [3:0] im;
    } exp_t;

    typedef struct {
        logic [3:0] pc;
        logic [7:0] data;
        logic       cf;
        int         lat;
        exp_t       e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[12];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [1:0] s, input logic [3:0] ld, input logic [3:0] i);
        exp_t e;
        e.sel   = s;
        e.loads = ld;
        e.im    = i;
        return e;
    endfunction

    function automatic vec_t mk(input logic [3:0] p, input logic [7:0] d, input logic c,
                                input int l, input logic [1:0] s, input logic [3:0] ld);
        vec_t v;
        v.pc   = p;
        v.data = d;
        v.cf   = c;
        v.lat  = l;
        v.e    = mk_exp(s, ld, d[3:0]);
        return v;
    endfunction

    // scoreboard: each execute strobe consumes exactly one queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!clr) begin
            if (exec) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_exec", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("exec_sel", sel, e.sel);
                    chk("exec_loads", {load_a, load_b, load_out, load_pc}, e.loads);
                    chk("exec_im", im, e.im);
                end
            end else begin
                chk("idle_loads", {load_a, load_b, load_out, load_pc}, 4'hF);
                chk("idle_sel", sel, 2'b11);
            end
        end
    end

    task automatic wait_req();
        int k = 0;
        while (rom_req !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("req_rise", rom_req, 1'b1);
    endtask

    task automatic fetch_one(input logic [3:0] p, input logic [7:0] d, input logic c,
                             input int lat, input exp_t e);
        pc = p;
        cf = c;
        wait_req();
        chk("rom_addr", rom_addr, p);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk("addr_stable", {rom_req, rom_addr}, {1'b1, p});
        end
        exp_q.push_back(e);
        rom_ack  = 1'b1;
        rom_data = d;
        @(negedge clk);
        chk("exec_after_ack", exec, 1'b1);
        rom_ack  = 1'b0;
        rom_data = 8'($urandom);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vt[0]  = mk(4'h3, 8'h35, 1'b0, 0, 2'b11, 4'b0111);
        vt[1]  = mk(4'h7, 8'hE7, 1'b1, 1, 2'b11, 4'b1111);
        vt[2]  = mk(4'h7, 8'hE7, 1'b0, 0, 2'b11, 4'b1110);
        vt[3]  = mk(4'h1, 8'h0A, 1'b0, 2, 2'b00, 4'b0111);
        vt[4]  = mk(4'h2, 8'h5A, 1'b0, 0, 2'b01, 4'b1011);
        vt[5]  = mk(4'h4, 8'h7C, 1'b0, 3, 2'b11, 4'b1011);
        vt[6]  = mk(4'h5, 8'h10, 1'b1, 0, 2'b01, 4'b0111);
        vt[7]  = mk(4'h6, 8'h40, 1'b0, 1, 2'b00, 4'b1011);
        vt[8]  = mk(4'h8, 8'h22, 1'b0, 0, 2'b10, 4'b0111);
        vt[9]  = mk(4'h9, 8'h63, 1'b0, 0, 2'b10, 4'b1011);
        vt[10] = mk(4'hA, 8'hB9, 1'b0, 2, 2'b11, 4'b1101);
        vt[11] = mk(4'hF, 8'hF4, 1'b1, 0, 2'b11, 4'b1110);

        clr = 1'b1; run = 1'b0; cf = 1'b0; rom_ack = 1'b0; rom_data = 8'h00; pc = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", rom_req, 1'b0);
        chk("rst_addr", rom_addr, 4'h0);
        chk("rst_exec", exec, 1'b0);
        chk("rst_loads", {load_a, load_b, load_out, load_pc}, 4'hF);
        chk("rst_im", im, 4'h0);
        chk("rst_sel", sel, 2'b11);
        chk("rst_flags", {fault, illegal}, 2'b00);
        clr = 1'b0;
        run = 1'b1;

        for (int i = 0; i < 12; i++)
            fetch_one(vt[i].pc, vt[i].data, vt[i].cf, vt[i].lat, vt[i].e);

        // ROM never answers: NOP execute after TIMEOUT fetch cycles, then refetch
        pc = 4'h9;
        wait_req();
        chk("tmo_addr", rom_addr, 4'h9);
        exp_q.push_back(mk_exp(2'b11, 4'hF, 4'h0));
        k = 0;
        while (exec !== 1'b1 && k < TMO + 10) begin
            if (rom_req) k++;
            @(negedge clk);
        end
        chk("tmo_exec", exec, 1'b1);
        chk("tmo_cycles", k, TMO);
        chk("tmo_fault", fault, 1'b1);
        #1;
        @(negedge clk);
        chk("tmo_refetch", {rom_req, rom_addr}, {1'b1, 4'h9});
        fetch_one(4'h9, 8'h7C, 1'b0, 0, mk_exp(2'b11, 4'b1011, 4'hC));
        chk("fault_sticky", fault, 1'b1);

        // reset lands on the same edge as an ack
        wait_req();
        rom_ack = 1'b1; rom_data = 8'h35; clr = 1'b1; run = 1'b0;
        @(negedge clk);
        chk("clr_req", rom_req, 1'b0);
        chk("clr_exec", exec, 1'b0);
        chk("clr_ir", im, 4'h0);
        chk("clr_fault", fault, 1'b0);
        clr = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("clr_ack_ignored", {rom_req, exec}, 2'b00);
        end
        rom_ack = 1'b0;

        // RUN dropped mid-fetch: instruction still completes, then IDLE
        run = 1'b1;
        pc  = 4'h5;
        wait_req();
        run = 1'b0;
        chk("stop_addr", rom_addr, 4'h5);
        repeat (3) begin
            @(negedge clk);
            chk("stop_req_held", rom_req, 1'b1);
        end
        exp_q.push_back(mk_exp(2'b01, 4'b1101, 4'h0));
        rom_ack = 1'b1; rom_data = 8'h90;
        @(negedge clk);
        chk("stop_exec", exec, 1'b1);
        rom_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stop_idle", {rom_req, exec}, 2'b00);
        end

        // undefined opcode 8'h80
        run = 1'b1;
        fetch_one(4'h2, 8'h80, 1'b0, 1, mk_exp(2'b11, 4'hF, 4'h0));
`ifdef TD4_ILLEGAL_TRAP_EN
        repeat (6) begin
            @(negedge clk);
            chk("trap_halt", {rom_req, illegal}, 2'b01);
        end
`else
        wait_req();
        chk("nop_illegal", illegal, 1'b0);
        fetch_one(4'h2, 8'hF4, 1'b0, 0, mk_exp(2'b11, 4'b1110, 4'h4));
`endif
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
